// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for if_id_buffer; the predecode flag wires
// exist only when IFID_PREDECODE_EN is defined.
interface if_id_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] Inst_in;
    logic [XLEN-1:0] PC_in;
    logic            if_valid;
    logic            if_ready;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] Inst_out;
    logic [XLEN-1:0] PC_out;
    logic [1:0]      count;
`ifdef IFID_PREDECODE_EN
    logic            is_branch;
    logic            is_jump;

    modport slave (
        input  Inst_in, PC_in, if_valid, flush, id_ready,
        output if_ready, id_valid, Inst_out, PC_out, count, is_branch, is_jump
    );
    modport master (
        output Inst_in, PC_in, if_valid, flush, id_ready,
        input  if_ready, id_valid, Inst_out, PC_out, count, is_branch, is_jump
    );
`else
    modport slave (
        input  Inst_in, PC_in, if_valid, flush, id_ready,
        output if_ready, id_valid, Inst_out, PC_out, count
    );
    modport master (
        output Inst_in, PC_in, if_valid, flush, id_ready,
        input  if_ready, id_valid, Inst_out, PC_out, count
    );
`endif
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID elastic buffer with flush and NOP-when-empty output.
// Optional head-entry predecode flags are enabled by defining IFID_PREDECODE_EN.
module if_id_buffer #(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h00000013)
) (
    input  logic          clk,
    input  logic          reset,
    if_id_buffer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            wptr_q, wptr_d;
    logic            rptr_q, rptr_d;
    logic [XLEN-1:0] inst_q [2];
    logic [XLEN-1:0] inst_d [2];
    logic [XLEN-1:0] pc_q   [2];
    logic [XLEN-1:0] pc_d   [2];
`ifdef IFID_PREDECODE_EN
    logic            br_q [2];
    logic            br_d [2];
    logic            jmp_q [2];
    logic            jmp_d [2];
    logic [6:0]      opcode_c;
`endif

    logic empty_c;
    logic full_c;
    logic enq_c;
    logic deq_c;

    assign empty_c = (state_q == ST_EMPTY);
    assign full_c  = (state_q == ST_FULL);
    assign enq_c   = bus.if_valid & ~full_c & ~bus.flush;
    assign deq_c   = ~empty_c & bus.id_ready & ~bus.flush;
`ifdef IFID_PREDECODE_EN
    assign opcode_c = bus.Inst_in[6:0];
`endif

    // Next-state, pointer and storage update
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
`ifdef IFID_PREDECODE_EN
        br_d    = br_q;
        jmp_d   = jmp_q;
`endif
        if (bus.flush) begin
            state_d = ST_EMPTY;
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
        end else begin
            if (enq_c) begin
                inst_d[wptr_q] = bus.Inst_in;
                pc_d[wptr_q]   = bus.PC_in;
`ifdef IFID_PREDECODE_EN
                br_d[wptr_q]   = (opcode_c == 7'b1100011);
                jmp_d[wptr_q]  = (opcode_c == 7'b1101111) || (opcode_c == 7'b1100111);
`endif
                wptr_d = ~wptr_q;
            end
            if (deq_c) begin
                rptr_d = ~rptr_q;
            end
            case (state_q)
                ST_EMPTY: if (enq_c) state_d = ST_ONE;
                ST_ONE: begin
                    if (enq_c && !deq_c)      state_d = ST_FULL;
                    else if (!enq_c && deq_c) state_d = ST_EMPTY;
                end
                ST_FULL:  if (deq_c) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Payload storage needs no reset: it is only observed through a valid count
    always_ff @(posedge clk) begin
        inst_q <= inst_d;
        pc_q   <= pc_d;
`ifdef IFID_PREDECODE_EN
        br_q   <= br_d;
        jmp_q  <= jmp_d;
`endif
    end

    assign bus.if_ready = ~full_c;
    assign bus.id_valid = ~empty_c;
    assign bus.count    = 2'(state_q);
    assign bus.Inst_out = empty_c ? NOP_INST : inst_q[rptr_q];
    assign bus.PC_out   = empty_c ? '0 : pc_q[rptr_q];
`ifdef IFID_PREDECODE_EN
    assign bus.is_branch = ~empty_c & br_q[rptr_q];
    assign bus.is_jump   = ~empty_c & jmp_q[rptr_q];
`endif

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Two-entry elastic buffer between the instruction-fetch stage and the decode stage of the RV32IM core. It captures each fetched instruction with its PC, decouples fetch from decode stalls with a valid/ready handshake, and discards in-flight instructions on a branch/jump redirect. When empty it presents a canonical NOP to decode, so decode never sees stale instructions.

## Interface
Parameters:
- XLEN, 32, width of the PC and instruction words.
- NOP_INST, 32'h00000013, instruction driven when no entry is valid (ADDI x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- Inst_in  input  XLEN  instruction from fetch.
- PC_in  input  XLEN  PC of Inst_in (PC_Temp of fetch).
- if_valid  input  1  fetch presents a valid Inst_in/PC_in this cycle.
- if_ready  output  1  buffer can accept an entry this cycle.
- flush  input  1  redirect taken (branch/jump); drop all entries.
- id_valid  output  1  head entry valid for decode.
- id_ready  input  1  decode consumes the head entry this cycle.
- Inst_out  output  XLEN  head instruction, or NOP_INST when empty.
- PC_out  output  XLEN  head PC, or 0 when empty.
- count  output  2  number of valid entries (0..2).
- is_branch, is_jump  output  1 each  predecode flags of head entry (only with IFID_PREDECODE_EN).

## Operation
- Storage: 2 entries {inst, pc[, flags]}, 1-bit write pointer, 1-bit read pointer, 2-bit count; pointers wrap 1 -> 0.
- States by count: EMPTY (0), ONE (1), FULL (2).
- Enqueue = if_valid & if_ready & ~flush; writes entry at wptr, wptr toggles.
- Dequeue = id_valid & id_ready & ~flush; rptr toggles.
- Transitions: EMPTY + enq -> ONE; ONE + enq only -> FULL; ONE + deq only -> EMPTY; ONE + enq + deq -> ONE; FULL + deq -> ONE; FULL + enq is impossible (if_ready=0).
- if_ready = (count != 2); it depends only on registered state, never combinationally on id_ready. A FULL buffer with a same-cycle dequeue still refuses the enqueue.
- id_valid = (count != 0); Inst_out/PC_out are driven from the entry at rptr, forced to NOP_INST/0 when count==0.
- flush: on the next edge count=0, wptr=rptr=0. An enqueue or dequeue offered in the flush cycle is dropped and is not counted.
- Reset (reset low): count=0, pointers=0, storage contents don't-care. Outputs are id_valid=0, if_ready=1, Inst_out=NOP_INST, PC_out=0, count=0, predecode flags 0. Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Latency: an instruction accepted at edge N appears on Inst_out with id_valid=1 in the cycle after edge N. There is no combinational bypass from Inst_in to Inst_out.
- Throughput: 1 instruction/cycle while decode accepts every cycle.
- Outputs are stable between edges; Inst_out/PC_out/flags are combinational muxes of registered storage only.
- flush at edge N: id_valid=0 after edge N. The first post-redirect instruction is accepted at edge N+1 at the earliest.

## Configuration
- IFID_PREDECODE_EN defined: each entry stores is_branch = (Inst_in[6:0]==7'b1100011) and is_jump = (Inst_in[6:0]==7'b1101111 || 7'b1100111), computed at enqueue and output for the head entry. Both flags are 0 when empty.
- IFID_PREDECODE_EN undefined: the is_branch/is_jump ports and storage bits are absent; all other behaviour is identical.

## Test plan
- Reset: hold reset low for 2 cycles with if_valid=1 -> id_valid=0, if_ready=1, Inst_out=32'h00000013, PC_out=0, count=0; no entry is captured.
- Streaming: id_ready=1, enqueue Inst 32'h00500093 @PC 0, then 32'h00A00113 @PC 4 on consecutive edges -> each appears one cycle after its enqueue, count stays 1, no drops.
- Backpressure: id_ready=0, offer 3 instructions (PC 0,4,8) -> count=2, if_ready=0, third not accepted. Then id_ready=1 for one cycle with PC 8 offered -> PC 0 is consumed and PC 8 is not accepted that cycle (count=1). Order observed at output: 0, 4, 8.
- Flush: buffer FULL (PC 0,4), assert flush with if_valid=1, PC_in=8 -> next cycle count=0, id_valid=0, Inst_out=NOP. The PC 8 entry is dropped; PC 0x20 enqueued the following cycle emerges next.
- Async reset mid-stream: FULL buffer, drive reset low between edges -> outputs take their reset values before the next clk edge.
- Predecode (macro defined): enqueue 32'h00208463 (BEQ) and 32'h008000EF (JAL) -> is_branch=1/is_jump=0 for the first head, then 0/1 for the second.
